// File: rtl/riscv_divider.sv
// RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring divider, one quotient bit per cycle.
// Divide-by-zero and signed overflow are resolved at start without iterating.
module riscv_divider #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvsr_q, dvsr_d, res_q, res_d;
  logic            sel_rem_q, sel_rem_d, negq_q, negq_d, negr_q, negr_d;

  logic            is_signed, s1, s2, div_zero, ovf;
  logic [XLEN-1:0] a_mag, b_mag, special_res;
  logic [XLEN-1:0] rem_sh, quo_n, rem_n, q_fin, r_fin;
  logic [XLEN:0]   trial;

  always_comb begin
    is_signed   = ~i_op[0];
    s1          = is_signed & i_rs1[XLEN-1];
    s2          = is_signed & i_rs2[XLEN-1];
    a_mag       = s1 ? -i_rs1 : i_rs1;
    b_mag       = s2 ? -i_rs2 : i_rs2;
    div_zero    = (i_rs2 == '0);
    ovf         = is_signed & (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (i_rs2 == '1);
    special_res = div_zero ? (i_op[1] ? i_rs1 : '1) : (i_op[1] ? '0 : i_rs1);
  end

  // One restoring step on the shifted {rem, quo} pair.
  always_comb begin
    rem_sh = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    trial  = {1'b0, rem_sh} - {1'b0, dvsr_q};
    rem_n  = trial[XLEN] ? rem_sh : trial[XLEN-1:0];
    quo_n  = {quo_q[XLEN-2:0], ~trial[XLEN]};
    q_fin  = negq_q ? -quo_n : quo_n;
    r_fin  = negr_q ? -rem_n : rem_n;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    res_d     = res_q;
    sel_rem_d = sel_rem_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (div_zero || ovf) begin
            res_d   = special_res;
            state_d = S_DONE;
          end else begin
            sel_rem_d = i_op[1];
            negq_d    = s1 ^ s2;
            negr_d    = s1;
            quo_d     = a_mag;
            rem_d     = '0;
            dvsr_d    = b_mag;
            cnt_d     = '0;
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        quo_d = quo_n;
        rem_d = rem_n;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN-1)) begin
          res_d   = sel_rem_q ? r_fin : q_fin;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Flush wins over everything, including the final iteration's result write.
    if (i_flush) begin
      state_d = S_IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      res_q     <= '0;
      sel_rem_q <= 1'b0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      res_q     <= res_d;
      sel_rem_q <= sel_rem_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
    end
  end

  assign o_busy   = (state_q != S_IDLE);
  assign o_valid  = (state_q == S_DONE);
  assign o_result = res_q;

endmodule

// File: tb/tb_riscv_divider.sv
// Self-checking bench for riscv_divider: directed table, corner sequences, random vs. model.
module tb_riscv_divider;

  logic        clk, rst_n, start, flush, busy, valid;
  logic [1:0]  op;
  logic [31:0] rs1, rs2, result;

  int total = 0;
  int bad   = 0;

  riscv_divider #(.XLEN(32)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_op     (op),
    .i_rs1    (rs1),
    .i_rs2    (rs2),
    .i_flush  (flush),
    .o_busy   (busy),
    .o_valid  (valid),
    .o_result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_edges;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain RV32M semantics using language-level signed/unsigned arithmetic.
  function automatic logic [31:0] model_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
    if (!o[0]) return o[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return o[1] ? a % b : a / b;
  endfunction

  function automatic int model_edges(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 0;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 32;
  endfunction

  // Edges counted after the accept edge until o_valid is seen; special cases show it immediately.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_edges, input string name);
    int lat;
    lat = -1;
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    start = 1'b0; rs1 = $urandom; rs2 = $urandom; op = 2'($urandom_range(0, 3));
    for (int k = 0; k <= 40; k++) begin
      if (valid) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_edges));
    check({name, "_result"}, result, exp_res);
    @(posedge clk); #1;
    check({name, "_idle_after"}, {30'b0, busy, valid}, 32'h0);
  endtask

  vec_t vecs[$];
  int   nvalid;

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
    #12;
    check("reset_busy_valid", {30'b0, busy, valid}, 32'h0);
    check("reset_result", result, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    vecs.push_back('{2'b01, 32'd100,        32'd7,          32'd14,         32, "divu_100_7"});
    vecs.push_back('{2'b11, 32'd100,        32'd7,          32'd2,          32, "remu_100_7"});
    vecs.push_back('{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32, "div_m7_2"});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32, "rem_m7_2"});
    vecs.push_back('{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          32, "rem_7_m2"});
    vecs.push_back('{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  0,  "div_by0"});
    vecs.push_back('{2'b11, 32'd5,          32'd0,          32'd5,          0,  "remu_by0"});
    vecs.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0,  "div_ovf"});
    vecs.push_back('{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          0,  "rem_ovf"});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32, "divu_max_max"});
    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_edges, vecs[i].name);

    // Second start while busy must be ignored.
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs1 = 32'hFFFF_FFFF; rs2 = 32'd1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); start = 1'b1; op = 2'b11; rs1 = 32'd10; rs2 = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    begin
      int lat;
      lat = -1;
      for (int k = 10; k <= 40; k++) begin
        if (valid) begin lat = k; break; end
        @(posedge clk); #1;
      end
      check("busy_start_latency", 32'(lat), 32'd32);
      check("busy_start_result", result, 32'hFFFF_FFFF);
    end
    nvalid = 0;
    repeat (36) begin @(posedge clk); #1; if (valid) nvalid++; end
    check("busy_start_no_second_valid", 32'(nvalid), 32'd0);
    run_op(2'b01, 32'd77, 32'd5, 32'd15, 32, "fresh_after_busy");

    // Flush mid-CALC leaves result and suppresses valid.
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 32, "pre_flush");
    @(negedge clk); start = 1'b1; op = 2'b01; rs1 = 32'd1000; rs2 = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_busy_drop", {31'b0, busy}, 32'h0);
    nvalid = 0;
    repeat (40) begin @(posedge clk); #1; if (valid) nvalid++; end
    check("flush_no_valid", 32'(nvalid), 32'd0);
    check("flush_result_kept", result, 32'd2);

    @(negedge clk); start = 1'b1; flush = 1'b1; op = 2'b00; rs1 = 32'd9; rs2 = 32'd0;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    nvalid = 0;
    for (int k = 0; k < 5; k++) begin
      if (valid || busy) nvalid++;
      @(posedge clk); #1;
    end
    check("start_flush_ignored", 32'(nvalid), 32'd0);
    check("start_flush_result", result, 32'd2);

    // Asynchronous reset mid-CALC.
    @(negedge clk); start = 1'b1; op = 2'b01; rs1 = 32'd1000; rs2 = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_busy_valid", {30'b0, busy, valid}, 32'h0);
    check("midreset_result", result, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    run_op(2'b01, 32'd1000, 32'd10, 32'd100, 32, "post_reset_divu");

    // Random operands against the reference model, with forced corner cases mixed in.
    for (int i = 0; i < 30; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      int          mode;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      mode = $urandom_range(0, 9);
      if (mode == 0) rb = 32'h0;
      else if (mode == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (mode == 2) rb = 32'($urandom_range(1, 15));
      else if (mode == 3) rb = -32'($urandom_range(1, 15));
      run_op(ro, ra, rb, model_res(ro, ra, rb), model_edges(ro, ra, rb), $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
